regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Sequences the single write port of the 32x32 register file. The port is shared by two sources:
//   - A: the in-order pipeline write-back stage.
//   - B: the multicycle unit (mul/div) write-back.
//  Arbitrates between them with starvation protection. Keeps a per-register busy scoreboard for
//  outstanding B operations and raises a decode stall on RAW/WAW hazards against them.
//  Sits between the WB stage / multicycle unit and the register file write inputs.
// PARAMETERS
//  NREG          32  number of architectural registers (x0 hardwired zero)
//  AW             5  register address width, log2(NREG)
//  DW            32  data width
//  STARVE_LIMIT   4  consecutive cycles B may be refused before it is force-granted (1..15)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  a_valid        in   1   pipeline WB write request
//  a_rd           in   AW  pipeline destination register
//  a_data         in   DW  pipeline write data
//  a_ready        out  1   A accepted this cycle; when 0 the pipeline holds WB and stalls
//  b_valid        in   1   multicycle result valid; held with b_rd/b_data until b_ready
//  b_rd           in   AW  multicycle destination register
//  b_data         in   DW  multicycle result
//  b_ready        out  1   B accepted this cycle
//  iss_valid      in   1   decode issues an op to the multicycle unit this cycle
//  iss_rd         in   AW  destination of that op
//  rs1Addr        in   AW  decode source 1, hazard check
//  rs2Addr        in   AW  decode source 2, hazard check
//  hazard_stall   out  1   decode must stall
//  RegWrite       out  1   register file write enable (registered)
//  WriteAddr      out  AW  register file write address (registered)
//  WriteData      out  DW  register file write data (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs are 0 at reset.
//   - Clears all busy bits, wait_cnt=0, state=A_PRI.
//   - RegWrite=0, WriteAddr=0, WriteData=0, a_ready=0, b_ready=0, hazard_stall=0.
//   - Reset mid-operation discards any accepted-but-unwritten result.
//  FSM, 2 states:
//   - A_PRI: a_ready=1; b_ready=!a_valid.
//   - B_FORCE: b_ready=1; a_ready=0 (A holds).
//  Starvation counter wait_cnt (4b):
//   - In A_PRI, cycle with b_valid && !b_ready -> wait_cnt+1.
//   - Any B grant -> wait_cnt=0.
//   - A_PRI -> B_FORCE when wait_cnt==STARVE_LIMIT-1 and B is refused again this cycle
//     (so B wins after exactly STARVE_LIMIT refusals).
//   - B_FORCE -> A_PRI after the B grant (always 1 cycle, since b_valid is held).
//   - ready outputs are combinational from state/valids.
//  Write port, 1-cycle latency:
//   - Winner accepted in cycle N drives RegWrite/WriteAddr/WriteData during N+1.
//   - Register file commits at the end of N+1; its write-bypass covers same-cycle reads.
//   - No acceptance in N -> RegWrite=0 in N+1.
//   - Winner with rd==0 is accepted (ready=1) but RegWrite=0.
//  Scoreboard busy[NREG-1:1], busy[0] is constant 0:
//   - Set: iss_valid && iss_rd!=0 sets busy[iss_rd] at the clock edge.
//   - Clear: a B grant with rd!=0 clears busy[b_rd] at the edge ending the accept cycle.
//     Decode in N+1 then sees the bypassed value.
//   - Same cycle, same rd, set and clear both present: set wins (new op owns rd).
//  hazard_stall (combinational), OR of:
//   - busy[rs1Addr], busy[rs2Addr]
//   - iss_valid && busy[iss_rd]  (WAW)
//   - !a_ready && a_valid  (WB held)
//  iss_valid while hazard_stall=1 is a protocol violation; the busy bit is still set.
//  A and B are never granted in the same cycle; at most one write per cycle.
// TESTING
//  1. Reset: rst_n=0 mid-write -> RegWrite=0 and hazard_stall=0 immediately; busy all clear
//     after release.
//  2. A only: a_valid=1, a_rd=5, a_data=32'h1234 in cycle N -> cycle N+1 RegWrite=1,
//     WriteAddr=5, WriteData=32'h1234.
//  3. Scoreboard: iss_valid, iss_rd=7; then rs1Addr=7 -> hazard_stall=1 until B writes
//     rd=7 (accepted in N), stall=0 in N+1.
//  4. Starvation: a_valid=1 every cycle, b_valid=1 from cycle 0, STARVE_LIMIT=4 ->
//     b_ready=1 at cycle 4, a_ready=0 that cycle, A resumes at cycle 5.
//  5. Collision: same cycle iss_rd=9 and B grant on rd=9 -> busy[9]=1 afterwards.
//     x0: B write to rd=0 -> b_ready=1, RegWrite stays 0.
//  6. No-contention: b_valid only -> b_ready=1 same cycle, write in next cycle, wait_cnt=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: pipeline WB (A) vs multicycle unit (B),
// with starvation forcing for B, a busy scoreboard for outstanding B results and decode stall.
module regfile_wb_arbiter #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] rs1Addr,
  input  logic [AW-1:0] rs2Addr,
  output logic          hazard_stall,
  output logic          RegWrite,
  output logic [AW-1:0] WriteAddr,
  output logic [DW-1:0] WriteData
);

  typedef enum logic [0:0] {
    A_PRI   = 1'b0,
    B_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_wait_cnt;
  logic [3:0]      w_wait_nxt;
  logic [NREG-1:1] r_busy;
  logic [NREG-1:0] w_busy_full;
  logic            w_a_grant;
  logic            w_b_grant;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;

  // Ready outputs are forced low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n) begin
      case (r_state)
        A_PRI: begin
          a_ready = 1'b1;
          b_ready = ~a_valid;
        end
        B_FORCE: begin
          a_ready = 1'b0;
          b_ready = 1'b1;
        end
        default: begin
          a_ready = 1'b0;
          b_ready = 1'b0;
        end
      endcase
    end else begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  assign w_a_grant = a_valid & a_ready;
  assign w_b_grant = b_valid & b_ready;

  // Next state and starvation count; B wins after exactly STARVE_LIMIT refusals.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      A_PRI: begin
        if (w_b_grant) begin
          w_wait_nxt = 4'd0;
        end else if (b_valid) begin
          if (r_wait_cnt == LIMIT_M1) begin
            w_state_nxt = B_FORCE;
          end else begin
            w_state_nxt = A_PRI;
          end
          w_wait_nxt = r_wait_cnt + 4'd1;
        end else begin
          w_wait_nxt = r_wait_cnt;
        end
      end
      B_FORCE: begin
        if (w_b_grant || !b_valid) begin
          w_state_nxt = A_PRI;
          w_wait_nxt  = 4'd0;
        end else begin
          w_state_nxt = B_FORCE;
        end
      end
      default: begin
        w_state_nxt = A_PRI;
        w_wait_nxt  = 4'd0;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= A_PRI;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Write port: the winner of cycle N is presented during N+1; x0 targets never assert RegWrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= {AW{1'b0}};
      r_wdata <= {DW{1'b0}};
    end else if (w_a_grant) begin
      r_we    <= (a_rd != {AW{1'b0}});
      r_waddr <= a_rd;
      r_wdata <= a_data;
    end else if (w_b_grant) begin
      r_we    <= (b_rd != {AW{1'b0}});
      r_waddr <= b_rd;
      r_wdata <= b_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Scoreboard: a new issue to rd takes precedence over a same-cycle B completion to rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {(NREG-1){1'b0}};
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (iss_valid && (iss_rd == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_b_grant && (b_rd == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end else begin
          r_busy[i] <= r_busy[i];
        end
      end
    end
  end

  assign w_busy_full = {r_busy, 1'b0};

  // Decode stall on RAW/WAW against outstanding B ops, or while WB is held.
  always_comb begin
    hazard_stall = 1'b0;
    if (rst_n) begin
      hazard_stall = w_busy_full[rs1Addr] | w_busy_full[rs2Addr] |
                     (iss_valid & w_busy_full[iss_rd]) | (a_valid & ~a_ready);
    end else begin
      hazard_stall = 1'b0;
    end
  end

  assign RegWrite  = r_we;
  assign WriteAddr = r_waddr;
  assign WriteData = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter, checked against a behavioural model
// of the arbitration, write-port and scoreboard rules.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic        hazard_stall;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;

  regfile_wb_arbiter #(.NREG(32), .AW(5), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .hazard_stall(hazard_stall), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit [31:0]   m_busy;
  int          m_refusals;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_bg;
  bit          obs_ar, obs_br, obs_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 32'd0;
    m_refusals = 0;
    m_we = 1'b0;
    m_waddr = 5'd0;
    m_wdata = 32'd0;
    m_bg = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                      input bit iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit force_b, e_ar, e_br, e_hs, ag;
    @(negedge clk);
    force_b = (m_refusals >= LIMIT);
    e_ar = !force_b;
    e_br = force_b || !av;
    e_hs = m_busy[r1] || m_busy[r2] || (av && !e_ar);
    if (iv && (e_hs || m_busy[ird])) iv = 1'b0;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    iss_valid = iv; iss_rd = ird; rs1Addr = r1; rs2Addr = r2;
    #1;
    obs_ar = a_ready; obs_br = b_ready; obs_hs = hazard_stall;
    check("a_ready", {31'd0, a_ready}, {31'd0, e_ar});
    check("b_ready", {31'd0, b_ready}, {31'd0, e_br});
    check("hazard_stall", {31'd0, hazard_stall}, {31'd0, e_hs});
    check("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
    if (m_we) begin
      check("WriteAddr", {27'd0, WriteAddr}, {27'd0, m_waddr});
      check("WriteData", WriteData, m_wdata);
    end
    ag   = av && e_ar;
    m_bg = bv && e_br;
    if (ag) begin
      m_we = (ard != 5'd0); m_waddr = ard; m_wdata = ad;
    end else if (m_bg) begin
      m_we = (brd != 5'd0); m_waddr = brd; m_wdata = bd;
    end else begin
      m_we = 1'b0;
    end
    if (m_bg) m_refusals = 0;
    else if (bv) m_refusals++;
    if (m_bg && brd != 5'd0) m_busy[brd] = 1'b0;
    if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    bit          bp;
    logic [4:0]  bprd;
    logic [31:0] bpd;
    rst_n = 1'b0;
    a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; rs1Addr = 5'd0; rs2Addr = 5'd0;
    model_reset();
    #3;
    check("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    check("rst_WriteAddr", {27'd0, WriteAddr}, 32'd0);
    check("rst_WriteData", WriteData, 32'd0);
    check("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_b_ready", {31'd0, b_ready}, 32'd0);
    check("rst_hazard", {31'd0, hazard_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A only: write lands the following cycle
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle();
    check("a_only_we", {31'd0, RegWrite}, 32'd1);
    check("a_only_addr", {27'd0, WriteAddr}, 32'd5);
    check("a_only_data", WriteData, 32'h1234);

    // Scoreboard RAW on x7 until B writes it
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    check("sb_stall_set", {31'd0, obs_hs}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB7, 1'b0, 5'd0, 5'd7, 5'd0);
    check("sb_stall_accept", {31'd0, obs_hs}, 32'd1);
    check("sb_b_ready", {31'd0, obs_br}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    check("sb_stall_clear", {31'd0, obs_hs}, 32'd0);
    check("sb_write_addr", {27'd0, WriteAddr}, 32'd7);

    // Starvation: B refused LIMIT times, granted on cycle LIMIT, A resumes next
    for (int c = 0; c <= LIMIT + 1; c++) begin
      step(1'b1, 5'd3, 32'(c), 1'b1, 5'd4, 32'hBB, 1'b0, 5'd0, 5'd0, 5'd0);
      if (c < LIMIT) begin
        check("starve_refuse", {31'd0, obs_br}, 32'd0);
      end else if (c == LIMIT) begin
        check("starve_b_grant", {31'd0, obs_br}, 32'd1);
        check("starve_a_hold", {31'd0, obs_ar}, 32'd0);
      end else begin
        check("starve_a_resume", {31'd0, obs_ar}, 32'd1);
      end
    end

    // Collision: issue and completion on x9 in the same cycle leave x9 busy
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    check("collide_busy9", {31'd0, obs_hs}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 5'd0, 5'd0);

    // x0 from B: accepted, never written
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0, 5'd0);
    check("x0_b_ready", {31'd0, obs_br}, 32'd1);
    idle();
    check("x0_no_write", {31'd0, RegWrite}, 32'd0);

    // Randomized traffic; B holds its request until granted
    bp = 1'b0; bprd = 5'd0; bpd = 32'd0;
    for (int n = 0; n < 600; n++) begin
      if (!bp && ($urandom_range(99) < 40)) begin
        bp = 1'b1; bprd = 5'($urandom_range(31)); bpd = $urandom;
      end
      step(($urandom_range(99) < 65), 5'($urandom_range(31)), $urandom,
           bp, bprd, bpd,
           ($urandom_range(99) < 30), 5'($urandom_range(31)),
           5'($urandom_range(31)), 5'($urandom_range(31)));
      if (m_bg) bp = 1'b0;
    end

    // Reset mid-write with busy bits outstanding
    step(1'b1, 5'd3, 32'hCAFE, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    check("pre_rst_we", {31'd0, RegWrite}, {31'd0, m_we});
    a_valid = 1'b1; rs1Addr = 5'd12; iss_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_we", {31'd0, RegWrite}, 32'd0);
    check("midrst_hazard", {31'd0, hazard_stall}, 32'd0);
    check("midrst_a_ready", {31'd0, a_ready}, 32'd0);
    check("midrst_b_ready", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int r = 0; r < 32; r++) begin
      rs1Addr = 5'(r);
      rs2Addr = 5'(31 - r);
      #1;
      check("post_rst_busy", {31'd0, hazard_stall}, 32'd0);
    end
    idle();
    check("post_rst_we", {31'd0, RegWrite}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212, 1'b0, 5'd0, 5'd0, 5'd0);
    check("b_only_ready", {31'd0, obs_br}, 32'd1);
    idle();
    check("b_only_addr", {27'd0, WriteAddr}, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
